l1_writeback_buffer: RTL and testbench
======================================

# l1_writeback_buffer

Write-back buffer and RAM port controller sitting directly downstream of the 4-entry L1 cache, between it and the 32×8 synchronous RAM. It queues dirty evictions, drains them to RAM in the background, and serves cache line fills from RAM, forwarding data still held in the buffer so a fill never returns stale RAM contents. It is the RAM's only master.

## Interface
- ADDR_W, 5, address width (RAM depth 2^ADDR_W).
- DATA_W, 8, data width.
- DEPTH, 4, buffer entries (power of two, ≥2).
- READ_LATENCY, 2, clock edges from the RAM sampling an address to ram_q being valid.

- clock  in  1  single clock, all logic on rising edge.
- reset  in  1  synchronous, active-high.
- wb_valid  in  1  eviction write request.
- wb_ready  out  1  buffer can accept; equals count < DEPTH.
- wb_addr  in  ADDR_W  evicted tag/address.
- wb_data  in  DATA_W  evicted value.
- rd_valid  in  1  fill request.
- rd_ready  out  1  high only in IDLE.
- rd_addr  in  ADDR_W  fill address.
- rd_resp_valid  out  1  one-cycle pulse, fill data valid.
- rd_resp_data  out  DATA_W  fill data.
- ram_address  out  ADDR_W  registered.
- ram_data  out  DATA_W  registered.
- ram_wren  out  1  registered, one cycle per RAM write.
- ram_q  in  DATA_W  RAM read data.
- count  out  $clog2(DEPTH)+1  occupied entries.
- busy  out  1  state != IDLE or count != 0.

## Operation
- Buffer: circular FIFO (head/tail pointers, count), entries {addr, data}.
- Write accept (wb_valid & wb_ready): if a non-head entry holds wb_addr, overwrite its data in place (coalesce, count unchanged); otherwise append at tail. The head entry is never coalesced into (it may be draining).
- FSM states: IDLE, READ_WAIT, RESP.
- IDLE, priority per cycle: (1) read accept; (2) drain; (3) nothing.
- Read accept, hit: rd_addr matches a buffered entry, or matches wb_addr accepted the same cycle (that write counts as older than the read). Data = youngest match; same-cycle write wins. Response pulses next cycle; stay IDLE; no RAM access.
- Read accept, miss: drive ram_address=rd_addr, ram_wren=0 next cycle; go READ_WAIT.
- READ_WAIT: count READ_LATENCY cycles, capture ram_q, go RESP. No drains; writes still accepted.
- RESP: rd_resp_valid=1 with captured data for one cycle, return IDLE.
- Drain (IDLE, no read accepted, count>0): next cycle ram_address/ram_data = head, ram_wren=1; pop head. Back-to-back drains allowed, one per cycle.
- Simultaneous append and pop: count unchanged; wb_ready does not depend on pop.
- Width: pointers wrap modulo DEPTH; count saturates nowhere (guarded by wb_ready).

## Timing
- Reset (sampled high at an edge): state IDLE, count=0, pointers 0, rd_resp_valid=0, rd_resp_data=0, ram_wren=0, ram_address=0, ram_data=0; wb_ready=1, rd_ready=1, busy=0 after that edge. Reset mid-read: request dropped, no response. Reset discards buffered writes.
- Hit latency: accept at edge E → rd_resp_valid high during cycle E..E+1.
- Miss latency: accept at E → ram_address valid E..E+1, ram_q captured at edge E+1+READ_LATENCY, rd_resp_valid high the following cycle: READ_LATENCY+2 cycles after accept.
- rd_ready=0 in READ_WAIT and RESP; back-to-back hits accepted every cycle.
- Drain: head popped at edge E; ram_wren=1 during E..E+1 only.

## Test plan
- Reset then idle: all outputs at reset values, wb_ready=1, rd_ready=1, count=0, ram_wren=0 for 10 cycles.
- Fill to full: 4 writes (addr 1..4, data 0x11..0x44) with rd_valid held high to block drains after first; then release → wb_ready=0 at count 4, drains write RAM in order 1,2,3,4, one ram_wren per cycle.
- Forwarding: write (7,0xA5) queued behind three others, read 7 → rd_resp_data=0xA5 one cycle after accept, no ram_wren=0 read cycle issued.
- Same-cycle hazard: wb (9,0x3C) and rd 9 accepted together → response 0x3C; coalesce: writes (5,0x01),(6,..),(5,0x02) → count=2, later RAM[5]=0x02.
- Miss: RAM[12]=0x77, empty buffer, read 12 → ram_address=12, rd_resp_data=0x77 exactly 4 cycles after accept; writes arriving during READ_WAIT buffered, drained after RESP.
- Reset asserted in READ_WAIT with 2 entries buffered → no rd_resp_valid, count=0, no further ram_wren.

Source files
------------

// File: rtl/l1_writeback_buffer.sv
// Write-back buffer and sole RAM master for the L1 cache.
// Dirty evictions are queued in a small circular FIFO and drained to RAM in the
// background. Line fills are served from RAM, with buffered data forwarded so a
// fill never sees stale RAM contents.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high. Ready never depends on valid. wb_ready depends only on the occupancy
// count. rd_ready is high only in IDLE. A requester may hold valid with stable
// payload for as long as it likes.
module l1_writeback_buffer #(
  parameter int ADDR_W       = 5,
  parameter int DATA_W       = 8,
  parameter int DEPTH        = 4,
  parameter int READ_LATENCY = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       wb_valid,
  output logic                       wb_ready,
  input  logic [ADDR_W-1:0]          wb_addr,
  input  logic [DATA_W-1:0]          wb_data,
  input  logic                       rd_valid,
  output logic                       rd_ready,
  input  logic [ADDR_W-1:0]          rd_addr,
  output logic                       rd_resp_valid,
  output logic [DATA_W-1:0]          rd_resp_data,
  output logic [ADDR_W-1:0]          ram_address,
  output logic [DATA_W-1:0]          ram_data,
  output logic                       ram_wren,
  input  logic [DATA_W-1:0]          ram_q,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       busy,
  output logic [1:0]                 dbg_state
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int LW = (READ_LATENCY < 1) ? 1 : $clog2(READ_LATENCY + 1);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_READ_WAIT = 2'd1;
  localparam logic [1:0] S_RESP      = 2'd2;

  logic [1:0]        state_q;
  logic [LW-1:0]     lat_q;
  logic [PW-1:0]     head_q, tail_q;
  logic [CW-1:0]     count_q;
  logic              resp_valid_q;
  logic [DATA_W-1:0] resp_data_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [DATA_W-1:0] ram_data_q;
  logic              ram_wren_q;

  logic [ADDR_W-1:0] buf_addr_q [DEPTH];
  logic [DATA_W-1:0] buf_data_q [DEPTH];

  logic              wb_fire, rd_fire;
  logic              buf_hit, coal, same_hit, hit, append, drain;
  logic [DATA_W-1:0] buf_hit_data, hit_data;
  logic [PW-1:0]     coal_idx;

  assign wb_ready = (count_q < CW'(DEPTH));
  assign rd_ready = (state_q == S_IDLE);
  assign wb_fire  = wb_valid & wb_ready;
  assign rd_fire  = rd_valid & rd_ready;

  // Scan the occupied entries from oldest to youngest. The last read match wins,
  // which gives the youngest copy. The head is skipped for coalescing because it
  // may be the entry draining this cycle.
  always_comb begin
    logic [PW-1:0] idx;
    idx          = '0;
    buf_hit      = 1'b0;
    buf_hit_data = '0;
    coal         = 1'b0;
    coal_idx     = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_q + PW'(k);
      if (CW'(k) < count_q) begin
        if (buf_addr_q[idx] == rd_addr) begin
          buf_hit      = 1'b1;
          buf_hit_data = buf_data_q[idx];
        end
        if ((k != 0) && (buf_addr_q[idx] == wb_addr)) begin
          coal     = 1'b1;
          coal_idx = idx;
        end
      end
    end
  end

  // A write accepted in the same cycle is older than the read, so its data wins.
  assign same_hit = wb_fire && (wb_addr == rd_addr);
  assign hit      = same_hit || buf_hit;
  assign hit_data = same_hit ? wb_data : buf_hit_data;
  assign append   = wb_fire & ~coal;
  assign drain    = rd_ready & ~rd_fire & (count_q != '0);

  // Buffer storage. Stale entries need no reset because the count gates them.
  always_ff @(posedge clock) begin
    if (append) begin
      buf_addr_q[tail_q] <= wb_addr;
      buf_data_q[tail_q] <= wb_data;
    end else if (wb_fire) begin
      buf_data_q[coal_idx] <= wb_data;
    end
  end

  // Control FSM, FIFO pointers and the registered RAM and response ports.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      lat_q        <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      ram_addr_q   <= '0;
      ram_data_q   <= '0;
      ram_wren_q   <= 1'b0;
    end else begin
      resp_valid_q <= 1'b0;
      ram_wren_q   <= 1'b0;
      tail_q       <= tail_q + PW'(append);
      count_q      <= count_q + CW'(append) - CW'(drain);
      case (state_q)
        S_IDLE: begin
          if (rd_fire) begin
            if (hit) begin
              resp_valid_q <= 1'b1;
              resp_data_q  <= hit_data;
            end else begin
              ram_addr_q <= rd_addr;
              lat_q      <= '0;
              state_q    <= S_READ_WAIT;
            end
          end else if (drain) begin
            ram_addr_q <= buf_addr_q[head_q];
            ram_data_q <= buf_data_q[head_q];
            ram_wren_q <= 1'b1;
            head_q     <= head_q + PW'(1);
          end
        end
        S_READ_WAIT: begin
          if (lat_q == LW'(READ_LATENCY)) begin
            resp_data_q <= ram_q;
            state_q     <= S_RESP;
          end else begin
            lat_q <= lat_q + LW'(1);
          end
        end
        S_RESP: begin
          resp_valid_q <= 1'b1;
          state_q      <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rd_resp_valid = resp_valid_q;
  assign rd_resp_data  = resp_data_q;
  assign ram_address   = ram_addr_q;
  assign ram_data      = ram_data_q;
  assign ram_wren      = ram_wren_q;
  assign count         = count_q;
  assign busy          = (state_q != S_IDLE) || (count_q != '0);
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_l1_writeback_buffer.sv
// Directed bench for l1_writeback_buffer, including a behavioural 32x8 RAM
// with a two-stage read pipeline.
module tb_l1_writeback_buffer;

  logic       clock = 1'b0;
  logic       reset;
  logic       wb_valid, rd_valid;
  logic       wb_ready, rd_ready;
  logic [4:0] wb_addr, rd_addr, ram_address;
  logic [7:0] wb_data, rd_resp_data, ram_data, ram_q;
  logic       rd_resp_valid, ram_wren, busy;
  logic [2:0] count;
  logic [1:0] dbg_state;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] mem [32];
  logic [7:0] rd_stage;

  // clock and reset
  always #5 clock = ~clock;

  l1_writeback_buffer #(.ADDR_W(5), .DATA_W(8), .DEPTH(4), .READ_LATENCY(2)) dut (
    .clock(clock), .reset(reset),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .rd_resp_valid(rd_resp_valid), .rd_resp_data(rd_resp_data),
    .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren), .ram_q(ram_q),
    .count(count), .busy(busy), .dbg_state(dbg_state)
  );

  // RAM model: write on wren, read data valid two edges after address sampling.
  always @(posedge clock) begin
    if (ram_wren) mem[ram_address] <= ram_data;
    rd_stage <= mem[ram_address];
    ram_q    <= rd_stage;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic wv, input logic [4:0] wa, input logic [7:0] wd,
                       input logic rv, input logic [4:0] ra);
    wb_valid = wv; wb_addr = wa; wb_data = wd;
    rd_valid = rv; rd_addr = ra;
  endtask

  task automatic expect_drain(input string tag, input logic [4:0] a, input logic [7:0] d);
    step();
    chk({tag, "_wren"}, ram_wren, 1'b1);
    chk({tag, "_addr"}, ram_address, a);
    chk({tag, "_data"}, ram_data, d);
  endtask

  initial begin
    int wren_seen;
    int resp_seen;
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    mem[12] = 8'h77;
    rd_stage = 8'h00;
    ram_q    = 8'h00;
    reset = 1'b1;
    drive(0, 0, 0, 0, 0);
    step();
    step();
    reset = 1'b0;

    // reset then idle
    chk("rst_wb_ready", wb_ready, 1'b1);
    chk("rst_rd_ready", rd_ready, 1'b1);
    chk("rst_count", count, 3'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_resp_valid", rd_resp_valid, 1'b0);
    chk("rst_resp_data", rd_resp_data, 8'h00);
    chk("rst_ram_addr", ram_address, 5'd0);
    chk("rst_ram_data", ram_data, 8'h00);
    chk("rst_state", dbg_state, 2'd0);
    wren_seen = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      wren_seen += int'(ram_wren) + int'(rd_resp_valid) + int'(count != 0);
    end
    chk("idle_quiet", wren_seen, 0);

    // fill to full, hits on entry 1 block the drain
    drive(1, 5'd1, 8'h11, 0, 0);
    step();
    chk("fill1_count", count, 3'd1);
    chk("fill1_wren", ram_wren, 1'b0);
    drive(1, 5'd2, 8'h22, 1, 5'd1);
    step();
    chk("fill2_count", count, 3'd2);
    chk("fill2_resp_valid", rd_resp_valid, 1'b1);
    chk("fill2_resp_data", rd_resp_data, 8'h11);
    chk("fill2_wren", ram_wren, 1'b0);
    drive(1, 5'd3, 8'h33, 1, 5'd1);
    step();
    drive(1, 5'd4, 8'h44, 1, 5'd1);
    step();
    chk("full_count", count, 3'd4);
    chk("full_wb_ready", wb_ready, 1'b0);
    chk("full_wren", ram_wren, 1'b0);
    drive(0, 0, 0, 0, 0);
    expect_drain("drain1", 5'd1, 8'h11);
    chk("drain1_count", count, 3'd3);
    chk("drain1_wb_ready", wb_ready, 1'b1);
    expect_drain("drain2", 5'd2, 8'h22);
    expect_drain("drain3", 5'd3, 8'h33);
    expect_drain("drain4", 5'd4, 8'h44);
    step();
    chk("fill_end_wren", ram_wren, 1'b0);
    chk("fill_end_count", count, 3'd0);
    chk("fill_end_busy", busy, 1'b0);

    // forwarding: 7 queued behind three others
    drive(1, 5'd20, 8'hA0, 1, 5'd20);
    step();
    chk("fwd_same_data", rd_resp_data, 8'hA0);
    drive(1, 5'd21, 8'hA1, 1, 5'd20);
    step();
    drive(1, 5'd22, 8'hA2, 1, 5'd20);
    step();
    drive(1, 5'd7, 8'hA5, 1, 5'd20);
    step();
    drive(0, 0, 0, 1, 5'd7);
    step();
    chk("fwd_resp_valid", rd_resp_valid, 1'b1);
    chk("fwd_resp_data", rd_resp_data, 8'hA5);
    chk("fwd_no_ram", ram_wren, 1'b0);
    chk("fwd_state_idle", dbg_state, 2'd0);
    chk("fwd_count", count, 3'd4);
    drive(0, 0, 0, 0, 0);
    expect_drain("fwd_d1", 5'd20, 8'hA0);
    expect_drain("fwd_d2", 5'd21, 8'hA1);
    expect_drain("fwd_d3", 5'd22, 8'hA2);
    expect_drain("fwd_d4", 5'd7, 8'hA5);
    step();

    // same-cycle hazard
    drive(1, 5'd9, 8'h3C, 1, 5'd9);
    step();
    chk("haz_resp_valid", rd_resp_valid, 1'b1);
    chk("haz_resp_data", rd_resp_data, 8'h3C);
    chk("haz_count", count, 3'd1);
    chk("haz_state", dbg_state, 2'd0);
    drive(0, 0, 0, 0, 0);
    expect_drain("haz_d", 5'd9, 8'h3C);
    step();

    // coalesce into a non-head entry
    drive(1, 5'd3, 8'h33, 1, 5'd3);
    step();
    drive(1, 5'd5, 8'h01, 1, 5'd3);
    step();
    drive(1, 5'd6, 8'h66, 1, 5'd3);
    step();
    chk("coal_pre_count", count, 3'd3);
    drive(1, 5'd5, 8'h02, 1, 5'd3);
    step();
    chk("coal_count", count, 3'd3);
    drive(0, 0, 0, 1, 5'd5);
    step();
    chk("coal_fwd_data", rd_resp_data, 8'h02);
    drive(0, 0, 0, 0, 0);
    expect_drain("coal_d1", 5'd3, 8'h33);
    expect_drain("coal_d2", 5'd5, 8'h02);
    expect_drain("coal_d3", 5'd6, 8'h66);
    step();
    chk("coal_ram5", mem[5], 8'h02);

    // miss: 12 from RAM, writes arrive while waiting
    drive(0, 0, 0, 1, 5'd12);
    step();
    chk("miss_ram_addr", ram_address, 5'd12);
    chk("miss_wren", ram_wren, 1'b0);
    chk("miss_rd_ready", rd_ready, 1'b0);
    chk("miss_busy", busy, 1'b1);
    drive(1, 5'd13, 8'hD1, 0, 0);
    step();
    chk("miss_e1_resp", rd_resp_valid, 1'b0);
    drive(1, 5'd14, 8'hD2, 0, 0);
    step();
    chk("miss_e2_resp", rd_resp_valid, 1'b0);
    drive(0, 0, 0, 0, 0);
    step();
    chk("miss_e3_resp", rd_resp_valid, 1'b0);
    chk("miss_e3_count", count, 3'd2);
    step();
    chk("miss_resp_valid", rd_resp_valid, 1'b1);
    chk("miss_resp_data", rd_resp_data, 8'h77);
    chk("miss_resp_wren", ram_wren, 1'b0);
    expect_drain("miss_d1", 5'd13, 8'hD1);
    chk("miss_d1_resp", rd_resp_valid, 1'b0);
    expect_drain("miss_d2", 5'd14, 8'hD2);
    step();
    chk("miss_end_busy", busy, 1'b0);

    // reset while waiting on a miss with two entries buffered
    drive(0, 0, 0, 1, 5'd12);
    step();
    drive(1, 5'd17, 8'hE1, 0, 0);
    step();
    drive(1, 5'd18, 8'hE2, 0, 0);
    step();
    chk("rstw_count_pre", count, 3'd2);
    chk("rstw_state_pre", dbg_state, 2'd1);
    drive(0, 0, 0, 0, 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rstw_count", count, 3'd0);
    chk("rstw_rd_ready", rd_ready, 1'b1);
    chk("rstw_resp", rd_resp_valid, 1'b0);
    wren_seen = 0;
    resp_seen = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      wren_seen += int'(ram_wren);
      resp_seen += int'(rd_resp_valid);
    end
    chk("rstw_no_wren", wren_seen, 0);
    chk("rstw_no_resp", resp_seen, 0);
    chk("rstw_ram17", mem[17], 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
